comparator_threshold_loader: RTL and testbench



---
 rtl/comparator_threshold_loader_pkg.sv | 18 +
 rtl/comparator_threshold_loader_sat_shift.sv | 27 ++
 rtl/comparator_threshold_loader.sv | 85 ++++++++
 tb/tb_comparator_threshold_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/comparator_threshold_loader_pkg.sv
// Shared types and constants for the comparator threshold-table loader.
package comparator_threshold_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned VECTOR_WIDTH_DEF = 920;
   localparam int unsigned CNT_WIDTH_DEF    = $clog2(VECTOR_WIDTH_DEF);
   localparam int unsigned MUL_WIDTH_DEF    = 16;
   localparam int unsigned FRAC_BITS_DEF    = 8;

   localparam int unsigned RESULT_MAX = (2 ** (CNT_WIDTH_DEF + 1)) - 1;
   localparam int unsigned ACC_WIDTH  = CNT_WIDTH_DEF + MUL_WIDTH_DEF;

endpackage

// File: rtl/comparator_threshold_loader_sat_shift.sv
// Drops the fractional bits of an accumulator value and clamps the integer part
// to the result RAM word width.
module threshold_sat_shift
   import comparator_threshold_loader_pkg::*;
#(
   parameter int unsigned ACC_W     = ACC_WIDTH,
   parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
   parameter int unsigned OUT_W     = CNT_WIDTH_DEF + 1
) (
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] result
);

   localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

   logic [ACC_W-1:0] shifted;

   always_comb begin
      shifted = acc >> FRAC_BITS;
      if (shifted > OUT_MAX) begin
         result = '1;
      end else begin
         result = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/comparator_threshold_loader.sv
// Fills the comparator threshold RAM with floor(c*K) for c = 0..VECTOR_WIDTH and
// shares the RAM port with the similarity datapath.
module comparator_threshold_loader
   import comparator_threshold_loader_pkg::*;
#(
   parameter int unsigned VECTOR_WIDTH = VECTOR_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH    = $clog2(VECTOR_WIDTH),
   parameter int unsigned MUL_WIDTH    = MUL_WIDTH_DEF,
   parameter int unsigned FRAC_BITS    = FRAC_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_Start,
   input  logic [MUL_WIDTH-1:0] i_ThreshMul,
   input  logic                 i_DataEn,
   output logic                 o_Busy,
   output logic                 o_Done,
   output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
   output logic [CNT_WIDTH:0]   o_BRAM_Din,
   output logic                 o_BRAM_En,
   output logic                 o_BRAM_WrEn
);

   localparam int unsigned          ACC_W    = CNT_WIDTH + MUL_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VECTOR_WIDTH);

   state_e               state_q, state_d;
   logic [MUL_WIDTH-1:0] r_Mul;
   logic [CNT_WIDTH-1:0] r_Idx;
   logic [ACC_W-1:0]     r_Acc;
   logic [CNT_WIDTH:0]   sat_val;
   logic                 last_write;

   assign last_write = (state_q == LOAD) && (r_Idx == LAST_IDX);

   threshold_sat_shift #(
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS),
      .OUT_W     (CNT_WIDTH + 1)
   ) u_sat_shift (
      .acc    (r_Acc),
      .result (sat_val)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_Start) state_d = LOAD;
         LOAD:    if (last_write) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         r_Mul   <= '0;
         r_Idx   <= '0;
         r_Acc   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && i_Start) begin
            r_Mul <= i_ThreshMul;
            r_Idx <= '0;
            r_Acc <= '0;
         end else if (state_q == LOAD && !last_write) begin
            r_Idx <= r_Idx + 1'b1;
            r_Acc <= r_Acc + ACC_W'(r_Mul);
         end
      end
   end

   // Address/data stay on the last written entry once idle; the comparator
   // ignores them whenever WrEn is low.
   always_comb begin
      o_Busy      = (state_q == LOAD);
      o_Done      = (state_q == DONE);
      o_BRAM_WrEn = (state_q == LOAD);
      o_BRAM_En   = (state_q == LOAD) | i_DataEn;
      o_BRAM_Addr = r_Idx;
      o_BRAM_Din  = sat_val;
   end

endmodule

// File: tb/tb_comparator_threshold_loader.sv
// Scoreboard bench: stimulus queues the expected table writes, a monitor checks
// every cycle against them.
module tb_comparator_threshold_loader;

   localparam int VW   = 920;
   localparam int CW   = 10;
   localparam int MW   = 16;
   localparam int FB   = 8;
   localparam int RMAX = (1 << (CW + 1)) - 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          i_Start = 1'b0;
   logic [MW-1:0] i_ThreshMul = '0;
   logic          i_DataEn = 1'b0;
   logic          o_Busy;
   logic          o_Done;
   logic [CW-1:0] o_BRAM_Addr;
   logic [CW:0]   o_BRAM_Din;
   logic          o_BRAM_En;
   logic          o_BRAM_WrEn;

   int checks = 0;
   int errors = 0;
   int exp_addr_q[$];
   int exp_din_q[$];
   bit final_pending = 1'b0;
   bit mon_en = 1'b0;

   comparator_threshold_loader #(
      .VECTOR_WIDTH (VW),
      .CNT_WIDTH    (CW),
      .MUL_WIDTH    (MW),
      .FRAC_BITS    (FB)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_Start     (i_Start),
      .i_ThreshMul (i_ThreshMul),
      .i_DataEn    (i_DataEn),
      .o_Busy      (o_Busy),
      .o_Done      (o_Done),
      .o_BRAM_Addr (o_BRAM_Addr),
      .o_BRAM_Din  (o_BRAM_Din),
      .o_BRAM_En   (o_BRAM_En),
      .o_BRAM_WrEn (o_BRAM_WrEn)
   );

   always #5 clk = ~clk;

   // Reference: entry[c] = floor(c * K / 2^FB), clamped to the RAM word.
   function automatic int ref_entry(int c, int k);
      longint p;
      p = (longint'(c) * longint'(k)) / (longint'(1) << FB);
      return (p > RMAX) ? RMAX : int'(p);
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load(int k);
      @(negedge clk);
      i_Start     = 1'b1;
      i_ThreshMul = MW'(k);
      for (int c = 0; c <= VW; c++) begin
         exp_addr_q.push_back(c);
         exp_din_q.push_back(ref_entry(c, k));
      end
      @(negedge clk);
      i_Start = 1'b0;
      check("first_write_en", int'(o_BRAM_WrEn), 1);
      check("first_write_addr", int'(o_BRAM_Addr), 0);
   endtask

   task automatic wait_done(input bit start_at_done);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (o_Done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", int'(seen), 1);
      if (start_at_done && seen) begin
         i_Start     = 1'b1;
         i_ThreshMul = MW'($urandom_range(1, 65535));
         @(negedge clk);
         i_Start = 1'b0;
      end
      repeat (6) @(negedge clk);
      check("queue_drained", exp_addr_q.size(), 0);
   endtask

   task automatic wait_write_idx(int idx);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (o_BRAM_WrEn && int'(o_BRAM_Addr) == idx) begin
            seen = 1'b1;
            break;
         end
      end
      check("reached_write_idx", int'(seen), 1);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2 i_DataEn = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: every write must be the next queued entry; Done exactly one
   // cycle after the final write; En mirrors i_DataEn whenever not loading.
   initial begin
      int ea, ed;
      forever begin
         @(negedge clk);
         if (mon_en && rstn) begin
            check("done_timing", int'(o_Done), int'(final_pending));
            final_pending = 1'b0;
            check("busy_vs_wren", int'(o_BRAM_WrEn), int'(o_Busy));
            if (o_BRAM_WrEn) begin
               check("en_during_load", int'(o_BRAM_En), 1);
               if (exp_addr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write actual_addr=%0d expected=none", o_BRAM_Addr);
               end else begin
                  ea = exp_addr_q.pop_front();
                  ed = exp_din_q.pop_front();
                  check("wr_addr", int'(o_BRAM_Addr), ea);
                  check("wr_data", int'(o_BRAM_Din), ed);
                  if (ea == VW) final_pending = 1'b1;
               end
            end else begin
               check("en_mirror", int'(o_BRAM_En), int'(i_DataEn));
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", int'(o_Busy), 0);
      check("rst_done", int'(o_Done), 0);
      check("rst_wren", int'(o_BRAM_WrEn), 0);
      check("rst_addr", int'(o_BRAM_Addr), 0);
      check("rst_din", int'(o_BRAM_Din), 0);
      check("rst_en_mirror", int'(o_BRAM_En), int'(i_DataEn));
      rstn   = 1'b1;
      mon_en = 1'b1;
      repeat (8) @(negedge clk);

      load(512);
      wait_done(1'b0);

      // Start coinciding with DONE->IDLE must be dropped.
      load(768);
      wait_done(1'b1);

      // Start and K change mid-load must be ignored.
      load(384);
      wait_write_idx(100);
      i_Start     = 1'b1;
      i_ThreshMul = MW'($urandom_range(1, 65535));
      @(negedge clk);
      i_Start = 1'b0;
      wait_done(1'b0);

      load(0);
      wait_done(1'b0);

      for (int n = 0; n < 2; n++) begin
         load(int'($urandom_range(0, 65535)));
         wait_done(1'b0);
      end

      // Reset mid-load: immediate idle, no Done, queue abandoned.
      load(1000);
      wait_write_idx(300);
      #2 rstn = 1'b0;
      #1;
      check("midrst_busy", int'(o_Busy), 0);
      check("midrst_wren", int'(o_BRAM_WrEn), 0);
      check("midrst_done", int'(o_Done), 0);
      exp_addr_q.delete();
      exp_din_q.delete();
      final_pending = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);

      load(256);
      wait_done(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
